// File: rtl/sb_trig_holdoff_scaler.sv
// Single-bin trigger hold-off and per-PPS scaler stage: turns the 40 MHz trigger level
// into a one-cycle CLK120 pulse, blocks re-triggers during hold-off and counts both outcomes.
`timescale 1ns/1ps
module sb_trig_holdoff_scaler #(
    parameter int HOLDOFF_WIDTH = 12,
    parameter int COUNT_WIDTH   = 24
) (
    input  logic                     CLK120,
    input  logic                     RESET,
    input  logic [1:0]               ENABLE40,
    input  logic                     TRIG_IN,
    input  logic                     ARM,
    input  logic [HOLDOFF_WIDTH-1:0] HOLDOFF,
    input  logic                     PPS,
    output logic                     TRIG_OUT,
    output logic                     BUSY,
    output logic [COUNT_WIDTH-1:0]   ACCEPT_SCALER,
    output logic [COUNT_WIDTH-1:0]   SUPPRESS_SCALER,
    output logic                     SCALER_VALID
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] cnt);
        if (cnt == {COUNT_WIDTH{1'b1}})
            return cnt;
        return cnt + 1'b1;
    endfunction

    state_t                   state;
    logic                     trig_r, trig_prev;
    logic                     pps_r, pps_prev;
    logic [1:0]               lcl_enable40;
    logic [HOLDOFF_WIDTH-1:0] ho_cnt;
    logic [COUNT_WIDTH-1:0]   accept_cnt, suppress_cnt;
    logic                     trig_edge, pps_edge, accept_hit, suppress_hit;

    assign trig_edge    = trig_r & ~trig_prev;
    assign pps_edge     = pps_r & ~pps_prev;
    assign accept_hit   = trig_edge & ARM & (state == IDLE);
    assign suppress_hit = trig_edge & (state == HOLD);

    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            state           <= IDLE;
            trig_r          <= 1'b0;
            trig_prev       <= 1'b0;
            pps_r           <= 1'b0;
            pps_prev        <= 1'b0;
            lcl_enable40    <= 2'd0;
            ho_cnt          <= '0;
            accept_cnt      <= '0;
            suppress_cnt    <= '0;
            TRIG_OUT        <= 1'b0;
            BUSY            <= 1'b0;
            ACCEPT_SCALER   <= '0;
            SUPPRESS_SCALER <= '0;
            SCALER_VALID    <= 1'b0;
        end else begin
            // input register stage
            trig_r       <= TRIG_IN;
            trig_prev    <= trig_r;
            pps_r        <= PPS;
            pps_prev     <= pps_r;
            lcl_enable40 <= ENABLE40;

            // edge / output register stage
            TRIG_OUT <= accept_hit;
            case (state)
                IDLE: begin
                    if (accept_hit) begin
                        ho_cnt <= HOLDOFF;
                        if (HOLDOFF != '0) begin
                            state <= HOLD;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // expiry leaves HOLD one cycle after the count reaches zero
                    if (ho_cnt == '0) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (lcl_enable40 == 2'd0) begin
                        ho_cnt <= ho_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            SCALER_VALID <= pps_edge;
            if (pps_edge) begin
                // a trigger coinciding with the PPS edge belongs to the new interval
                ACCEPT_SCALER   <= accept_cnt;
                SUPPRESS_SCALER <= suppress_cnt;
                accept_cnt      <= accept_hit ? CNT_ONE : '0;
                suppress_cnt    <= suppress_hit ? CNT_ONE : '0;
            end else begin
                if (accept_hit)
                    accept_cnt <= sat_inc(accept_cnt);
                if (suppress_hit)
                    suppress_cnt <= sat_inc(suppress_cnt);
            end
        end
    end
endmodule

// File: tb/tb_sb_trig_holdoff_scaler.sv
// Directed bench for sb_trig_holdoff_scaler: a default-width instance and a 4-bit
// counter instance share one stimulus; expected values are hand-computed per scenario.
`timescale 1ns/1ps
module tb_sb_trig_holdoff_scaler;
    logic        clk120 = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en40 = 2'd0;
    logic        trig_in = 1'b0;
    logic        arm = 1'b0;
    logic [11:0] holdoff = 12'd0;
    logic        pps = 1'b0;

    logic        trig_out, busy, scaler_valid;
    logic [23:0] acc_sc, sup_sc;
    logic        trig_out_s, busy_s, scaler_valid_s;
    logic [3:0]  acc_sc_s, sup_sc_s;

    int n_tests = 0;
    int n_fail  = 0;
    int to_cnt = 0;
    int busy_cnt = 0;

    sb_trig_holdoff_scaler #(.HOLDOFF_WIDTH(12), .COUNT_WIDTH(24)) dut (
        .CLK120(clk120), .RESET(rst), .ENABLE40(en40), .TRIG_IN(trig_in), .ARM(arm),
        .HOLDOFF(holdoff), .PPS(pps), .TRIG_OUT(trig_out), .BUSY(busy),
        .ACCEPT_SCALER(acc_sc), .SUPPRESS_SCALER(sup_sc), .SCALER_VALID(scaler_valid)
    );

    sb_trig_holdoff_scaler #(.HOLDOFF_WIDTH(12), .COUNT_WIDTH(4)) dut_s (
        .CLK120(clk120), .RESET(rst), .ENABLE40(en40), .TRIG_IN(trig_in), .ARM(arm),
        .HOLDOFF(holdoff), .PPS(pps), .TRIG_OUT(trig_out_s), .BUSY(busy_s),
        .ACCEPT_SCALER(acc_sc_s), .SUPPRESS_SCALER(sup_sc_s), .SCALER_VALID(scaler_valid_s)
    );

    always #5 clk120 = ~clk120;

    always @(negedge clk120) begin
        en40 = (en40 == 2'd2) ? 2'd0 : en40 + 2'd1;
        if (trig_out) to_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk120);
        #1;
    endtask

    task automatic trig_level(input int len);
        trig_in = 1'b1;
        repeat (len) tick();
        trig_in = 1'b0;
    endtask

    task automatic trig_train(input int n, input int period);
        for (int k = 0; k < n; k++) begin
            trig_level(3);
            repeat (period - 3) tick();
        end
    endtask

    task automatic pps_pulse();
        pps = 1'b1;
        repeat (4) tick();
        pps = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_tests++; if (trig_out !== 1'b0) begin n_fail++; $display("FAIL reset_trig_out got %b want 0", trig_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (acc_sc !== 24'd0 || sup_sc !== 24'd0) begin n_fail++; $display("FAIL reset_scalers got %0d/%0d want 0/0", acc_sc, sup_sc); end
        n_tests++; if (scaler_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", scaler_valid); end
        n_tests++; if ({trig_out_s, busy_s, scaler_valid_s, acc_sc_s, sup_sc_s} !== 11'd0) begin
            n_fail++; $display("FAIL reset_small got %b want 0", {trig_out_s, busy_s, scaler_valid_s, acc_sc_s, sup_sc_s}); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic_accept();
        int pulses = 0, first = -1, busy_n = 0;
        logic busy2 = 1'b0;
        arm = 1'b1; holdoff = 12'd4;
        tick();
        trig_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk120);
            if (trig_out) begin pulses++; if (first < 0) first = i; end
            if (busy) busy_n++;
            if (i == 2) busy2 = busy;
            if (i == 3) trig_in = 1'b0;
        end
        tick();
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL basic_pulse_count got %0d want 1", pulses); end
        n_tests++; if (first != 2) begin n_fail++; $display("FAIL basic_latency got %0d want 2", first); end
        n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b want 1", busy2); end
        n_tests++; if (busy_n < 10 || busy_n > 15) begin n_fail++; $display("FAIL basic_busy_len got %0d want 10..15", busy_n); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
        pps_pulse();
        n_tests++; if (acc_sc !== 24'd1 || sup_sc !== 24'd0) begin n_fail++; $display("FAIL basic_scalers got %0d/%0d want 1/0", acc_sc, sup_sc); end
        n_tests++; if (acc_sc_s !== 4'd1) begin n_fail++; $display("FAIL basic_small_acc got %0d want 1", acc_sc_s); end
    endtask

    task automatic test_suppression();
        int base, vcnt = 0, vidx = -1, waited = 0;
        holdoff = 12'd100; arm = 1'b1;
        base = to_cnt;
        trig_train(5, 30);
        while (busy !== 1'b0 && waited < 400) begin tick(); waited++; end
        n_tests++; if (waited >= 400) begin n_fail++; $display("FAIL supp_busy_timeout got busy=%b want 0", busy); end
        n_tests++; if (to_cnt - base != 1) begin n_fail++; $display("FAIL supp_trig_out got %0d want 1", to_cnt - base); end
        pps = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk120);
            if (scaler_valid) begin vcnt++; vidx = i; end
            if (i == 4) pps = 1'b0;
        end
        tick();
        n_tests++; if (vcnt != 1) begin n_fail++; $display("FAIL supp_valid_count got %0d want 1", vcnt); end
        n_tests++; if (vidx != 2) begin n_fail++; $display("FAIL supp_valid_latency got %0d want 2", vidx); end
        n_tests++; if (acc_sc !== 24'd1) begin n_fail++; $display("FAIL supp_accept got %0d want 1", acc_sc); end
        n_tests++; if (sup_sc !== 24'd4 || sup_sc_s !== 4'd4) begin n_fail++; $display("FAIL supp_suppress got %0d/%0d want 4/4", sup_sc, sup_sc_s); end
    endtask

    task automatic test_zero_holdoff_disarm();
        int base, bb;
        holdoff = 12'd0; arm = 1'b1;
        tick();
        base = to_cnt; bb = busy_cnt;
        trig_train(5, 6);
        n_tests++; if (to_cnt - base != 5) begin n_fail++; $display("FAIL zero_trig_out got %0d want 5", to_cnt - base); end
        n_tests++; if (busy_cnt - bb != 0) begin n_fail++; $display("FAIL zero_busy got %0d want 0", busy_cnt - bb); end
        arm = 1'b0;
        base = to_cnt;
        trig_train(3, 6);
        n_tests++; if (to_cnt - base != 0) begin n_fail++; $display("FAIL disarm_trig_out got %0d want 0", to_cnt - base); end
        arm = 1'b1;
        pps_pulse();
        n_tests++; if (acc_sc !== 24'd5 || sup_sc !== 24'd0) begin n_fail++; $display("FAIL zero_scalers got %0d/%0d want 5/0", acc_sc, sup_sc); end
    endtask

    task automatic test_pps_coincidence();
        int base;
        holdoff = 12'd0; arm = 1'b1;
        base = to_cnt;
        trig_train(7, 6);
        trig_in = 1'b1; pps = 1'b1;
        repeat (3) tick();
        trig_in = 1'b0;
        repeat (3) tick();
        pps = 1'b0;
        repeat (3) tick();
        n_tests++; if (to_cnt - base != 8) begin n_fail++; $display("FAIL coinc_trig_out got %0d want 8", to_cnt - base); end
        n_tests++; if (acc_sc !== 24'd7 || acc_sc_s !== 4'd7) begin n_fail++; $display("FAIL coinc_latched got %0d/%0d want 7/7", acc_sc, acc_sc_s); end
        pps_pulse();
        n_tests++; if (acc_sc !== 24'd1 || sup_sc !== 24'd0) begin n_fail++; $display("FAIL coinc_next got %0d/%0d want 1/0", acc_sc, sup_sc); end
    endtask

    task automatic test_saturation();
        holdoff = 12'd0; arm = 1'b1;
        trig_train(20, 6);
        pps_pulse();
        n_tests++; if (acc_sc_s !== 4'd15) begin n_fail++; $display("FAIL sat_small_acc got %0d want 15", acc_sc_s); end
        n_tests++; if (acc_sc !== 24'd20) begin n_fail++; $display("FAIL sat_wide_acc got %0d want 20", acc_sc); end
        n_tests++; if (sup_sc_s !== 4'd0) begin n_fail++; $display("FAIL sat_small_sup got %0d want 0", sup_sc_s); end
    endtask

    task automatic test_holdoff_change();
        int bb;
        holdoff = 12'd4; arm = 1'b1;
        bb = busy_cnt;
        trig_level(3);
        holdoff = 12'd2; arm = 1'b0;
        repeat (30) tick();
        n_tests++; if (busy_cnt - bb < 10 || busy_cnt - bb > 15) begin n_fail++; $display("FAIL hochg_first got %0d want 10..15", busy_cnt - bb); end
        arm = 1'b1;
        bb = busy_cnt;
        trig_level(3);
        repeat (20) tick();
        n_tests++; if (busy_cnt - bb < 4 || busy_cnt - bb > 9) begin n_fail++; $display("FAIL hochg_second got %0d want 4..9", busy_cnt - bb); end
    endtask

    task automatic test_reset_mid_hold();
        int base;
        holdoff = 12'd4095; arm = 1'b1;
        trig_level(3);
        repeat (50) tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rsthold_busy_before got %b want 1", busy); end
        #3 rst = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0 || busy_s !== 1'b0) begin n_fail++; $display("FAIL rsthold_busy got %b/%b want 0/0", busy, busy_s); end
        n_tests++; if (acc_sc !== 24'd0 || acc_sc_s !== 4'd0) begin n_fail++; $display("FAIL rsthold_scaler got %0d/%0d want 0/0", acc_sc, acc_sc_s); end
        n_tests++; if (trig_out !== 1'b0 || scaler_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_pulses got %b/%b want 0/0", trig_out, scaler_valid); end
        tick();
        rst = 1'b0;
        repeat (2) tick();
        base = to_cnt;
        trig_level(3);
        repeat (3) tick();
        n_tests++; if (to_cnt - base != 1) begin n_fail++; $display("FAIL rsthold_next_accept got %0d want 1", to_cnt - base); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rsthold_next_busy got %b want 1", busy); end
    endtask

    initial begin
        test_reset();
        test_basic_accept();
        test_suppression();
        test_zero_holdoff_disarm();
        test_pps_coincidence();
        test_saturation();
        test_holdoff_change();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sb_trig_holdoff_scaler.md
# sb_trig_holdoff_scaler

Downstream stage of the 40 MHz compatibility single-bin trigger. Converts the trigger level (high for one 40 MHz tick, i.e. three CLK120 cycles) into a single-cycle CLK120 pulse. Enforces a programmable hold-off, counted in 40 MHz ticks, after each accepted trigger. Counts accepted and suppressed triggers per PPS interval and presents the latched counts as scalers for the register interface.

## Interface
Parameters:
- HOLDOFF_WIDTH, 12: width of the hold-off setting, in 40 MHz ticks.
- COUNT_WIDTH, 24: width of the scaler counters.

Ports:
- CLK120  in  1  120 MHz system clock. One clock; reset is asynchronous and active-high.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE40  in  2  40 MHz phase. Value 0 marks the downsampled cycle.
- TRIG_IN  in  1  single-bin trigger level from the upstream stage.
- ARM  in  1  1 = triggers may be accepted.
- HOLDOFF  in  HOLDOFF_WIDTH  hold-off length in 40 MHz ticks. Sampled when a trigger is accepted.
- PPS  in  1  PPS level, already synchronous to CLK120.
- TRIG_OUT  out  1  one-CLK120-cycle accepted-trigger pulse.
- BUSY  out  1  high while in hold-off.
- ACCEPT_SCALER  out  COUNT_WIDTH  accepted triggers in the last complete PPS interval.
- SUPPRESS_SCALER  out  COUNT_WIDTH  triggers rejected by hold-off in the last complete PPS interval.
- SCALER_VALID  out  1  one-cycle pulse when both scalers update.

## Operation
- Input registering: TRIG_IN, PPS and ENABLE40 are each registered once (TRIG_R, PPS_R, LCL_ENABLE40).
- Trigger edge: TRIG_EDGE = TRIG_R & !TRIG_PREV. A level that lasts any number of cycles yields exactly one edge.
- PPS edge: PPS_EDGE = PPS_R & !PPS_PREV.
- State IDLE, on TRIG_EDGE:
  - If ARM=1: TRIG_OUT pulses, ACCEPT_CNT increments, HO_CNT loads HOLDOFF.
    - HOLDOFF=0: remain in IDLE.
    - Otherwise: go to HOLD.
  - If ARM=0: the edge is ignored and not counted.
- State HOLD:
  - BUSY=1.
  - HO_CNT decrements on each cycle with LCL_ENABLE40==0.
  - When HO_CNT reaches 0 (on a decrement from 1), go to IDLE on the next cycle.
  - TRIG_EDGE in HOLD gives no TRIG_OUT and increments SUPPRESS_CNT, regardless of ARM.
  - ARM deasserted in HOLD does not shorten the hold-off.
- Counters:
  - ACCEPT_CNT and SUPPRESS_CNT saturate at 2^COUNT_WIDTH-1; they never wrap.
  - On PPS_EDGE, the current counts are copied to ACCEPT_SCALER/SUPPRESS_SCALER, SCALER_VALID pulses, and the counters restart.
  - If a counted trigger edge coincides with PPS_EDGE: the latched value excludes that trigger, and the counter restarts at 1.
- HOLDOFF change: a change during HOLD has no effect until the next accepted trigger.
- Reset: asynchronous. All registers clear, state = IDLE, and all outputs are 0 (scalers = 0, BUSY = 0). Reset during HOLD aborts the hold-off; the first edge after release is accepted if ARM=1.

## Timing
- TRIG_OUT latency: rising TRIG_IN at CLK120 edge n produces TRIG_OUT high in cycle n+2 (input register + edge/output register), for exactly 1 cycle.
- BUSY rises in the same cycle as TRIG_OUT (HOLDOFF≠0).
- BUSY falls within 3·HOLDOFF+3 CLK120 cycles of TRIG_OUT, and no earlier than 3·(HOLDOFF-1)+1 cycles after it.
- The same-cycle ordering between hold-off expiry and a new edge is fixed: a TRIG_EDGE in the cycle where the state returns to IDLE is accepted.
- SCALER_VALID and the scaler updates appear 2 cycles after PPS rises. The scalers hold their value until the next PPS_EDGE.
- Throughput: one accepted trigger per 40 MHz tick at most, limited by the upstream level width.

## Test plan
- Basic accept: ARM=1, HOLDOFF=4, one 3-cycle TRIG_IN → a single 1-cycle TRIG_OUT 2 cycles after the rise; BUSY high for 10–15 cycles.
- Suppression: HOLDOFF=100, 5 TRIG_IN levels spaced 30 cycles apart, then PPS → ACCEPT_SCALER=1, SUPPRESS_SCALER=4, one SCALER_VALID pulse.
- Zero hold-off and disarm: HOLDOFF=0, triggers every 6 cycles → each gives TRIG_OUT and BUSY stays 0. ARM=0 → no TRIG_OUT, both counters unchanged.
- PPS coincidence: a trigger edge in the same cycle as the PPS edge, with 7 prior accepts → ACCEPT_SCALER=7, and the next interval's count starts at 1.
- Saturation: COUNT_WIDTH=4, 20 accepted triggers with HOLDOFF=0, then PPS → ACCEPT_SCALER=15.
- Reset mid-hold: HOLDOFF=4095, accept a trigger, pulse RESET after 50 cycles → all outputs 0 immediately, and the next trigger is accepted.
